mem_port_sched: RTL

- Sequencer and arbiter for the single-port 8-bit data/instruction RAM shared by the IF stage (reads only) and the MEM stage (reads and writes).
- Arbitrates between the two requesters, latches the winner's command and drives one-cycle RAM strobes.
- Counts configurable RAM wait states, returns read data with a one-cycle ack pulse, and generates pipeline stalls.
- Prevents IF starvation with a bounded MEM-priority counter.

---
 rtl/mem_port_sched.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/mem_port_sched.sv
// Arbiter/sequencer for the single-port RAM shared by the IF stage (reads) and MEM stage (r/w).
// Optional MEM_PORT_SCHED_POSTED_WRITE_EN: MEM writes ack in their strobe cycle and skip DONE.
module mem_port_sched #(
    parameter int unsigned WAIT_CYCLES = 1,
    parameter int unsigned STARVE_MAX  = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       if_req,
    input  logic [7:0] if_addr,
    output logic       if_ack,
    output logic [7:0] if_rdata,
    input  logic       mem_req,
    input  logic       mem_we,
    input  logic [7:0] mem_addr,
    input  logic [7:0] mem_wdata,
    output logic       mem_ack,
    output logic [7:0] mem_rdata,
    output logic [7:0] ram_addr,
    output logic [7:0] ram_wdata,
    output logic       ram_re,
    output logic       ram_we,
    input  logic [7:0] ram_rdata,
    output logic       stall_if,
    output logic       stall_mem,
    output logic       busy
);

    localparam int unsigned WW = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
    localparam int unsigned SW = (STARVE_MAX > 0) ? $clog2(STARVE_MAX + 1) : 1;
    localparam logic [WW-1:0] WAIT_INIT  = WW'(WAIT_CYCLES);
    localparam logic [SW-1:0] STARVE_TOP = SW'(STARVE_MAX);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t        state_q, state_d;
    logic          owner_q, owner_d;  // 1 = MEM owns the current access
    logic          we_q, we_d;
    logic [WW-1:0] wait_q, wait_d;
    logic [SW-1:0] starve_q, starve_d;
    logic [7:0]    addr_q, addr_d;
    logic [7:0]    wdata_q, wdata_d;
    logic [7:0]    if_rdata_q, if_rdata_d;
    logic [7:0]    mem_rdata_q, mem_rdata_d;
    logic          re_q, re_d;
    logic          wstb_q, wstb_d;
    logic          if_wins, mem_wins, posted_wr;

    // IF only beats a contending MEM once MEM has taken STARVE_MAX grants in a row.
    assign if_wins  = if_req && (!mem_req || ((STARVE_MAX != 0) && (starve_q == STARVE_TOP)));
    assign mem_wins = mem_req && !if_wins;

`ifdef MEM_PORT_SCHED_POSTED_WRITE_EN
    assign posted_wr = owner_q && we_q;
`else
    assign posted_wr = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        we_d        = we_q;
        wait_d      = wait_q;
        starve_d    = starve_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        if_rdata_d  = if_rdata_q;
        mem_rdata_d = mem_rdata_q;
        re_d        = 1'b0;
        wstb_d      = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (if_wins || mem_wins) begin
                    owner_d = mem_wins;
                    we_d    = mem_wins && mem_we;
                    addr_d  = mem_wins ? mem_addr : if_addr;
                    wdata_d = mem_wins ? mem_wdata : 8'h00;
                    re_d    = !(mem_wins && mem_we);
                    wstb_d  = mem_wins && mem_we;
                    wait_d  = WAIT_INIT;
                    state_d = BUSY;
                    if (if_wins || !if_req) begin
                        starve_d = '0;
                    end else if (starve_q != STARVE_TOP) begin
                        starve_d = starve_q + 1'b1;
                    end
                end
            end
            BUSY: begin
                if (wait_q == '0) begin
                    if (!we_q) begin
                        if (owner_q) begin
                            mem_rdata_d = ram_rdata;
                        end else begin
                            if_rdata_d = ram_rdata;
                        end
                    end
                    state_d = posted_wr ? IDLE : DONE;
                end else begin
                    wait_d = wait_q - 1'b1;
                end
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            owner_q     <= 1'b0;
            we_q        <= 1'b0;
            wait_q      <= '0;
            starve_q    <= '0;
            addr_q      <= 8'h00;
            wdata_q     <= 8'h00;
            if_rdata_q  <= 8'h00;
            mem_rdata_q <= 8'h00;
            re_q        <= 1'b0;
            wstb_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            we_q        <= we_d;
            wait_q      <= wait_d;
            starve_q    <= starve_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            if_rdata_q  <= if_rdata_d;
            mem_rdata_q <= mem_rdata_d;
            re_q        <= re_d;
            wstb_q      <= wstb_d;
        end
    end

    assign ram_addr  = addr_q;
    assign ram_wdata = wdata_q;
    assign ram_re    = re_q;
    assign ram_we    = wstb_q;
    assign if_rdata  = if_rdata_q;
    assign mem_rdata = mem_rdata_q;
    assign if_ack    = (state_q == DONE) && !owner_q;
`ifdef MEM_PORT_SCHED_POSTED_WRITE_EN
    assign mem_ack   = ((state_q == DONE) && owner_q) || wstb_q;
`else
    assign mem_ack   = (state_q == DONE) && owner_q;
`endif
    assign stall_if  = if_req && !if_ack;
    assign stall_mem = mem_req && !mem_ack;
    assign busy      = (state_q != IDLE);

endmodule
